controlador_bcd: RTL

Sequencer between the Booth signed multiplier and the binario_a_BCD converter.
- Accepts a 16-bit two's-complement product over a valid/ready handshake.
- Splits it into sign and 15-bit magnitude, launches the converter with a one-cycle start pulse, and waits for its done pulse under a timeout.
- Latches the 20-bit BCD result and presents it with sign and status to the display stage until that stage accepts it.

---
 rtl/controlador_bcd.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/controlador_bcd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// controlador_bcd : hands a signed product to the binary-to-BCD converter and
//                   presents the signed BCD result to the display stage.
// Revision 1.0
// ============================================================================
module controlador_bcd #(
    parameter int ANCHO_PROD = 16,
    parameter int TIMEOUT    = 255,
    parameter int GUARDA     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ANCHO_PROD-1:0] producto,
    input  logic                  producto_valido,
    output logic                  producto_listo,
    output logic                  bcd_inicio,
    output logic [ANCHO_PROD-2:0] bcd_bin,
    input  logic [19:0]           bcd_codigo,
    input  logic                  bcd_done,
    output logic [19:0]           resultado_bcd,
    output logic                  resultado_signo,
    output logic                  resultado_valido,
    input  logic                  resultado_aceptado,
    output logic                  error_timeout,
    output logic                  ocupado
);
    localparam int c_ANCHO_TO = $clog2(TIMEOUT + 1);
    localparam int c_ANCHO_GU = (GUARDA > 0) ? $clog2(GUARDA + 1) : 1;
    localparam logic [ANCHO_PROD-1:0] c_MIN_NEG   = {1'b1, {(ANCHO_PROD-1){1'b0}}};
    localparam logic [ANCHO_PROD-2:0] c_UNO_MAG   = (ANCHO_PROD-1)'(1);
    localparam logic [c_ANCHO_TO-1:0] c_LIMITE    = c_ANCHO_TO'(TIMEOUT);
    localparam logic [c_ANCHO_TO-1:0] c_UNO_TO    = c_ANCHO_TO'(1);
    localparam logic [c_ANCHO_GU-1:0] c_GUARDA    = c_ANCHO_GU'(GUARDA);
    localparam logic [c_ANCHO_GU-1:0] c_UNO_GU    = c_ANCHO_GU'(1);
    // The most negative product has no magnitude in bcd_bin, so its BCD image is a constant.
    localparam logic [19:0]           c_BCD_MIN   = 20'h32768;

    typedef enum logic [2:0] {
        INACTIVO = 3'd0,
        MAGNITUD = 3'd1,
        LANZAR   = 3'd2,
        ESPERA   = 3'd3,
        ENTREGA  = 3'd4
    } estado_t;

    estado_t               r_estado;
    logic [ANCHO_PROD-1:0] r_producto;
    logic [c_ANCHO_TO-1:0] r_cuenta;
    logic [c_ANCHO_GU-1:0] r_guarda;
    logic [c_ANCHO_GU-1:0] w_guarda_dec;
    logic [ANCHO_PROD-2:0] w_magnitud;
    logic                  w_negativo;
    logic                  w_desborde;

    assign w_negativo   = r_producto[ANCHO_PROD-1];
    assign w_desborde   = (r_producto == c_MIN_NEG);
    assign w_magnitud   = w_negativo ? (~r_producto[ANCHO_PROD-2:0] + c_UNO_MAG)
                                     : r_producto[ANCHO_PROD-2:0];
    assign w_guarda_dec = (r_guarda != '0) ? (r_guarda - c_UNO_GU) : r_guarda;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado         <= INACTIVO;
            r_producto       <= '0;
            r_cuenta         <= '0;
            r_guarda         <= '0;
            producto_listo   <= 1'b0;
            bcd_inicio       <= 1'b0;
            bcd_bin          <= '0;
            resultado_bcd    <= '0;
            resultado_signo  <= 1'b0;
            resultado_valido <= 1'b0;
            error_timeout    <= 1'b0;
            ocupado          <= 1'b0;
        end else begin
            r_guarda   <= w_guarda_dec;
            bcd_inicio <= 1'b0;
            case (r_estado)
                INACTIVO: begin
                    if (producto_valido && producto_listo) begin
                        r_producto     <= producto;
                        producto_listo <= 1'b0;
                        ocupado        <= 1'b1;
                        r_estado       <= MAGNITUD;
                    end else begin
                        producto_listo <= (w_guarda_dec == '0);
                    end
                end
                MAGNITUD: begin
                    resultado_signo <= w_negativo;
                    if (w_desborde) begin
                        resultado_bcd    <= c_BCD_MIN;
                        resultado_valido <= 1'b1;
                        r_estado         <= ENTREGA;
                    end else begin
                        bcd_bin    <= w_magnitud;
                        bcd_inicio <= 1'b1;
                        r_estado   <= LANZAR;
                    end
                end
                LANZAR: begin
                    r_cuenta <= '0;
                    r_estado <= ESPERA;
                end
                ESPERA: begin
                    // A done arriving on the last allowed cycle still counts as success.
                    if (bcd_done) begin
                        resultado_bcd    <= bcd_codigo;
                        r_guarda         <= c_GUARDA;
                        resultado_valido <= 1'b1;
                        r_estado         <= ENTREGA;
                    end else if (r_cuenta == c_LIMITE) begin
                        resultado_bcd    <= '0;
                        error_timeout    <= 1'b1;
                        resultado_valido <= 1'b1;
                        r_estado         <= ENTREGA;
                    end else begin
                        r_cuenta <= r_cuenta + c_UNO_TO;
                    end
                end
                ENTREGA: begin
                    if (resultado_aceptado) begin
                        resultado_valido <= 1'b0;
                        error_timeout    <= 1'b0;
                        ocupado          <= 1'b0;
                        producto_listo   <= (w_guarda_dec == '0);
                        r_estado         <= INACTIVO;
                    end
                end
                default: begin
                    r_estado <= INACTIVO;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
